// File: rtl/signed_bin2bcd_seq.sv
// Sequential signed/unsigned binary-to-BCD converter (double dabble, one bit per clock).
// Start/busy/done handshake; sign and BCD outputs only move on completion or reset.

module signed_bin2bcd_seq_dig (
  input  logic [3:0] i_Nib,
  output logic [3:0] o_Nib
);
  assign o_Nib = (i_Nib >= 4'd5) ? i_Nib + 4'd3 : i_Nib;
endmodule

module signed_bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3,
  parameter bit SIGNED = 1'b1
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Start,
  input  logic [WIDTH-1:0]      i_Val,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic                  o_Sign,
  output logic [4*DIGITS-1:0]   o_Bcd
);
  localparam int BW = 4*DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH+1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Largest magnitude that must be representable: |-2^(W-1)| when signed.
  localparam logic [63:0] MAXMAG = SIGNED ? (64'd1 << (WIDTH-1))
                                          : ((64'd1 << WIDTH) - 64'd1);

  generate
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("signed_bin2bcd_seq: WIDTH must be 2..32");
    end
    if (pow10(DIGITS) <= MAXMAG) begin : g_bad_digits
      $error("signed_bin2bcd_seq: DIGITS too small for WIDTH");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [SW-1:0]   sr_q, sr_d;
  logic            sign_q, sign_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            osign_q, osign_d;
  logic [BW-1:0]   bcd_q, bcd_d;

  logic [BW-1:0]   bcd_adj;
  logic [SW-1:0]   sr_shift;
  logic [WIDTH-1:0] mag;
  logic            neg;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_dig
      signed_bin2bcd_seq_dig u_dig (
        .i_Nib (sr_q[WIDTH+4*g +: 4]),
        .o_Nib (bcd_adj[4*g +: 4])
      );
    end
  endgenerate

  assign sr_shift = {bcd_adj, sr_q[WIDTH-1:0]} << 1;
  assign neg      = SIGNED && i_Val[WIDTH-1];
  assign mag      = neg ? (~i_Val + WIDTH'(1)) : i_Val;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    sign_d  = sign_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    osign_d = osign_q;
    bcd_d   = bcd_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          sign_d  = neg;
          sr_d    = {{BW{1'b0}}, mag};
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          bcd_d   = sr_shift[SW-1:WIDTH];
          osign_d = sign_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      sign_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      osign_q <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      sign_q  <= sign_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      osign_q <= osign_d;
      bcd_q   <= bcd_d;
    end
  end

  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_Sign = osign_q;
  assign o_Bcd  = bcd_q;
endmodule

// File: tb/tb_signed_bin2bcd_seq.sv
// Scoreboard bench for signed_bin2bcd_seq: three instances (signed 8-bit, unsigned 8-bit, signed 16-bit).
module tb_signed_bin2bcd_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic st0 = 1'b0, st1 = 1'b0, st2 = 1'b0;
  logic [7:0]  v0 = '0, v1 = '0;
  logic [15:0] v2 = '0;
  logic d0_busy, d0_done, d0_sign; logic [11:0] d0_bcd;
  logic d1_busy, d1_done, d1_sign; logic [11:0] d1_bcd;
  logic d2_busy, d2_done, d2_sign; logic [19:0] d2_bcd;

  signed_bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b1)) u_s8 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(st0), .i_Val(v0),
    .o_Busy(d0_busy), .o_Done(d0_done), .o_Sign(d0_sign), .o_Bcd(d0_bcd));
  signed_bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .SIGNED(1'b0)) u_u8 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(st1), .i_Val(v1),
    .o_Busy(d1_busy), .o_Done(d1_done), .o_Sign(d1_sign), .o_Bcd(d1_bcd));
  signed_bin2bcd_seq #(.WIDTH(16), .DIGITS(5), .SIGNED(1'b1)) u_s16 (
    .i_Clk(clk), .i_Rst(rst), .i_Start(st2), .i_Val(v2),
    .o_Busy(d2_busy), .o_Done(d2_done), .o_Sign(d2_sign), .o_Bcd(d2_bcd));

  typedef struct {logic s; logic [19:0] b; int due;} exp_t;
  exp_t q0[$], q1[$], q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int d, input logic s, input logic [19:0] b);
    exp_t e;
    int sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL done_unexpected dut%0d: got done sign=%0b bcd=%h at cycle %0d, expected no done", d, s, b, cyc);
      return;
    end
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (s !== e.s || b !== e.b || cyc != e.due) begin
      errors++;
      $display("FAIL result dut%0d: got sign=%0b bcd=%h cycle=%0d expected sign=%0b bcd=%h cycle=%0d",
               d, s, b, cyc, e.s, e.b, e.due);
    end
  endtask

  // Call away from the clock edge; returns 1 time unit after the accepting edge.
  task automatic issue(input int d, input logic [15:0] v, input logic s, input logic [19:0] b);
    exp_t e;
    case (d)
      0: begin st0 = 1'b1; v0 = v[7:0]; end
      1: begin st1 = 1'b1; v1 = v[7:0]; end
      default: begin st2 = 1'b1; v2 = v; end
    endcase
    @(posedge clk); #1;
    e.s = s; e.b = b; e.due = cyc + ((d == 2) ? 16 : 8);
    case (d)
      0: begin q0.push_back(e); st0 = 1'b0; end
      1: begin q1.push_back(e); st1 = 1'b0; end
      default: begin q2.push_back(e); st2 = 1'b0; end
    endcase
  endtask

  task automatic wait_idle(input int d);
    int sz;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk); #1;
      sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
      if (sz == 0) return;
    end
    errors++; checks++;
    $display("FAIL timeout dut%0d: got %0d pending results expected 0", d, sz);
  endtask

  function automatic logic [19:0] ref8(input logic [7:0] v);
    int m;
    m = v[7] ? 256 - int'(v) : int'(v);
    return 20'(((m / 100) << 8) | (((m / 10) % 10) << 4) | (m % 10));
  endfunction

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (d0_done) mon(0, d0_sign, {8'h0, d0_bcd});
        if (d1_done) mon(1, d1_sign, {8'h0, d1_bcd});
        if (d2_done) mon(2, d2_sign, d2_bcd);
      end
      begin
        #2000000;
        $display("FAIL watchdog: got no end of stimulus expected completion");
        $fatal(1, "watchdog");
      end
      begin
        repeat (3) @(negedge clk);
        chk("reset_s8",  {d0_busy, d0_done, d0_sign, d0_bcd}, '0);
        chk("reset_u8",  {d1_busy, d1_done, d1_sign, d1_bcd}, '0);
        chk("reset_s16", {d2_busy, d2_done, d2_sign, d2_bcd}, '0);
        rst = 1'b0;
        @(negedge clk);

        // -128: busy for exactly 8 cycles, result held afterwards
        issue(0, 16'h80, 1'b1, 20'h128);
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          chk($sformatf("busy_hi_%0d", k), {d0_busy, d0_done}, 2'b10);
        end
        @(negedge clk); chk("busy_lo_at_done", d0_busy, 1'b0);
        @(negedge clk); chk("done_one_cycle", d0_done, 1'b0);
        repeat (3) @(negedge clk);
        chk("bcd_held", {d0_sign, d0_bcd}, {1'b1, 12'h128});
        wait_idle(0);

        issue(0, 16'h7F, 1'b0, 20'h127); wait_idle(0);
        issue(0, 16'h00, 1'b0, 20'h000); wait_idle(0);

        // start during SHIFT ignored, start in done cycle accepted
        issue(0, 16'h9C, 1'b1, 20'h100);
        @(negedge clk); @(negedge clk);
        st0 = 1'b1; v0 = 8'h05;
        @(negedge clk);
        st0 = 1'b0; v0 = 8'hAA;
        for (int n = 0; n < 20 && !d0_done; n++) @(negedge clk);
        #1;
        issue(0, 16'h05, 1'b0, 20'h005);
        wait_idle(0);

        issue(0, 16'hFF, 1'b1, 20'h001); wait_idle(0);

        // reset mid-conversion aborts and clears outputs
        st0 = 1'b1; v0 = 8'h7F;
        @(posedge clk); #1; st0 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outputs", {d0_busy, d0_done, d0_sign, d0_bcd}, '0);
        @(negedge clk);
        rst = 1'b0;
        issue(0, 16'h81, 1'b1, 20'h127);
        wait_idle(0);

        issue(1, 16'hFF, 1'b0, 20'h255); wait_idle(1);
        issue(1, 16'h80, 1'b0, 20'h128); wait_idle(1);
        issue(1, 16'h00, 1'b0, 20'h000); wait_idle(1);

        issue(2, 16'h8000, 1'b1, 20'h32768); wait_idle(2);
        issue(2, 16'h7FFF, 1'b0, 20'h32767); wait_idle(2);
        issue(2, 16'hFFFF, 1'b1, 20'h00001); wait_idle(2);

        for (int v = 0; v < 256; v++) begin
          issue(0, 16'(v), v[7], ref8(8'(v)));
          wait_idle(0);
        end

        repeat (3) @(negedge clk);
        chk("pending_left", q0.size() + q1.size() + q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    join
  end
endmodule
